// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for a shared 4:1 data mux.
//
// One requester at a time owns the mux. The owner index drives the select
// pair {s1,s0}, and `out` is the selected data word.
//
// Optional build macro MUX4_ARB_TIMEOUT_EN: when it is defined, an owner that
// has held the grant for HOLD_MAX cycles is preempted, provided another
// requester is waiting.
//
// Ports:
//   clk, rst_n       rising-edge clock; asynchronous active-low reset
//   req[3:0]         request lines; bit n belongs to data input i<n>
//   i0..i3 [W-1:0]   requester data words
//   grant[3:0]       one-hot grant, or all zeros when idle (from flops)
//   s1, s0           mux select = owner index; holds its last value when idle
//   valid            high while a grant is active
//   out[W-1:0]       selected data word, decoded from the registered select
module mux4_rr_arbiter #(
  parameter int unsigned W        = 1,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  output logic [3:0]   grant,
  output logic         s1,
  output logic         s0,
  output logic         valid,
  output logic [W-1:0] out
);

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] others;
  logic       hold_hit;
  logic       rel;

  // Search p+1, p+2, p+3, then p (mod 4); the first set bit wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!found && m[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    others   = req & ~(4'b0001 << owner_q);
    hold_hit = (cnt_q == 8'(HOLD_MAX - 1));
    // With no competing request, a timeout never fires; the owner keeps the grant.
    rel      = !req[owner_q] || (TimeoutEn && hold_hit && (|others));
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d = StGrant;
          owner_d = rr_pick(req, ptr_q);
          cnt_d   = 8'd0;
        end
      end
      StGrant: begin
        if (rel) begin
          ptr_d = owner_q;
          if (|others) begin
            owner_d = rr_pick(others, owner_q);
            cnt_d   = 8'd0;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ptr resets to 3 so that requester 0 wins the first pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    grant = (state_q == StGrant) ? (4'b0001 << owner_q) : 4'b0000;
    valid = (state_q == StGrant);
    s1    = owner_q[1];
    s0    = owner_q[0];
    unique case (owner_q)
      2'd0:    out = i0;
      2'd1:    out = i1;
      2'd2:    out = i2;
      default: out = i3;
    endcase
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int unsigned W        = 4;
  localparam int unsigned HOLD_MAX = 4;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] d [4];
  logic [3:0]   grant;
  logic         s1, s0, valid;
  logic [W-1:0] out;

  int n_checks;
  int n_fail;

  // Reference model state, kept as plain integers.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cnt;

  mux4_rr_arbiter #(.W(W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .i0    (d[0]),
    .i1    (d[1]),
    .i2    (d[2]),
    .i3    (d[3]),
    .grant (grant),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 3;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] m;
    bit         rel;
    if (!m_busy) begin
      if (r != 4'b0) begin
        m_busy  = 1'b1;
        m_owner = pick(r, m_ptr);
        m_cnt   = 0;
      end
    end else begin
      m   = r;
      m[m_owner] = 1'b0;
      rel = !r[m_owner] || (TO && m_cnt == HOLD_MAX - 1 && m != 4'b0);
      if (rel) begin
        m_ptr = m_owner;
        if (m != 4'b0) begin
          m_owner = pick(m, m_owner);
          m_cnt   = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    check("grant", grant, eg);
    check("valid", valid, m_busy);
    check("sel", {s1, s0}, m_owner[1:0]);
    check("out", out, d[m_owner]);
  endtask

  // One clock: advance the model on the edge, then compare away from the edge.
  task automatic cycle();
    @(posedge clk);
    model_step(req);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_grant", grant, 4'b0000);
    check("rst_sel", {s1, s0}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    model_reset();
    do_reset();

    // Single requester on input 2.
    req  = 4'b0100;
    d[2] = 4'h1;
    cycle();
    check("single_grant", grant, 4'b0100);
    check("single_sel", {s1, s0}, 2'b10);
    check("single_out", out, 4'h1);
    req = 4'b0000;
    cycle();
    check("single_idle", valid, 1'b0);

    // Reset mid-grant, then restart from requester 0.
    req = 4'b1111;
    cycle();
    cycle();
    do_reset();
    req = 4'b1111;
    cycle();
    check("post_rst", grant, 4'b0001);

    // Fairness: each owner drops for one cycle, then re-raises.
    req = 4'b1110; cycle(); check("rr1", grant, 4'b0010);
    req = 4'b1101; cycle(); check("rr2", grant, 4'b0100);
    req = 4'b1011; cycle(); check("rr3", grant, 4'b1000);
    req = 4'b0111; cycle(); check("rr4", grant, 4'b0001);

    // Back-to-back handover from owner 1 to owner 3.
    do_reset();
    req = 4'b0010; cycle(); check("ho_own1", grant, 4'b0010);
    req = 4'b1010; cycle(); check("ho_hold", grant, 4'b0010);
    req = 4'b1000; cycle(); check("ho_move", grant, 4'b1000);
    check("ho_sel", {s1, s0}, 2'b11);

    // Two steady requesters: alternate every HOLD_MAX cycles only with timeout.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (TO) check("to_alt", grant, ((i / HOLD_MAX) % 2 == 0) ? 4'b0001 : 4'b0010);
      else    check("to_hold", grant, 4'b0001);
    end

    // Lone hog: keeps the grant long enough for cnt to saturate.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      cycle();
      check("hog", grant, 4'b0001);
    end

    // Randomized traffic: request lines flip occasionally so grants persist.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      for (int k = 0; k < 4; k++) d[k] = W'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
